core_trace_monitor: RTL and testbench
=====================================

Name: core_trace_monitor

Overview:
- Parametrised, memory-mapped debug monitor for one processing element core. Sits on the PE's MMIO host bus beside the core.
- Snapshots halted status, predicates and all registers into local buffers, and keeps a free-running cycle counter.
- Adds a predicate-change trace FIFO with cycle timestamps, freeze-on-halt, and registered one-cycle MMIO reads and writes.

Parameters:
WORD_WIDTH  32  MMIO data width and core register width
NUM_PREDICATES  8  core predicate count; must be less than WORD_WIDTH
NUM_REGISTERS  8  core register count
TRACE_DEPTH  16  trace FIFO entries; power of two, at least 2
INDEX_WIDTH  8  MMIO index width; must satisfy 8+NUM_REGISTERS <= 2^INDEX_WIDTH

Ports:
clock  in  1  positive-edge clock
reset  in  1  synchronous, active-high
enable  in  1  block enable, active-high
read_req  in  1  host read request
read_index  in  INDEX_WIDTH  read word index
read_ack  out  1  read acknowledge; read_data valid this cycle
read_data  out  WORD_WIDTH  read data
write_req  in  1  host write request
write_index  in  INDEX_WIDTH  write word index
write_data  in  WORD_WIDTH  write data
write_ack  out  1  write acknowledge
core_halted  in  1  core halted flag
core_predicates  in  NUM_PREDICATES  core predicate state
core_registers  in  NUM_REGISTERS x WORD_WIDTH  core register file, unpacked array

Behaviour:
- Reset (synchronous, active-high; clock clock):
  - read_ack, write_ack and read_data = 0.
  - All buffers, the cycle counter and CONTROL = 0.
  - FIFO empty; overflow and frozen cleared.
  - Any in-flight acknowledge is dropped.
- Sampling: each cycle with enable && !frozen, the buffers load core_halted, core_predicates and core_registers.
- Cycle counter increments by 1 on each cycle with enable && !frozen && !core_halted; it wraps modulo 2^WORD_WIDTH.
- Register map (read_index):
  - 0 STATUS: bit0 halted buffer, bit1 frozen, bit2 overflow, bits[15:8] FIFO count.
  - 1 PREDICATES: buffer, zero-extended.
  - 2 CONTROL (read/write): bit0 arm, bit1 freeze_on_halt, bit2 clear (write-only, self-clearing, reads 0).
  - 3 CYCLE: counter value.
  - 4 TRACE: oldest FIFO entry, popped on read. When the FIFO is empty it returns 0 and does not pop.
  - 8..8+NUM_REGISTERS-1: register buffer [index-8].
  - All other indices: read 0; writes are discarded but acknowledged.
- Read handshake:
  - A request is accepted when read_req=1 and read_ack=0.
  - read_ack=1 one cycle later for exactly one cycle, with registered read_data.
  - A request held high restarts the cycle after the ack, so throughput is 1 read per 2 cycles.
  - The TRACE pop occurs at acceptance.
- Write handshake: same as reads; write_ack one cycle after acceptance. The register write takes effect at acceptance.
- Read and write requests are independent and may be accepted in the same cycle.
- enable=0: requests are still accepted and acknowledged. Reads return 0; writes are discarded; no sampling, counting or capture.
- Trace capture condition: arm && enable && !frozen && core_predicates != predicate buffer.
  - Entry = {cycle[WORD_WIDTH-NUM_PREDICATES-1:0], core_predicates}, timestamped with the current counter value before increment.
  - The predicate buffer is 0 after reset, so nonzero predicates on the first armed cycle are captured.
- FIFO full:
  - A capture with no simultaneous pop is dropped and sets overflow (sticky).
  - A simultaneous pop and capture when full succeeds, count unchanged, no overflow.
  - Pop and capture when empty: the pop returns 0 and the capture is stored.
- Freeze: on a cycle with freeze_on_halt=1, enable=1 and core_halted=1, frozen sets at the next edge. The halted buffer captures 1 on that same edge. Frozen holds buffers, counter and trace until clear or reset.
- Clear (write CONTROL with bit2=1):
  - Empties the FIFO and zeroes the counter; clears overflow and frozen.
  - arm and freeze_on_halt load from bits 0 and 1 of the same write.
  - Clear has priority over a same-cycle capture.

Test Plan:
- Reset, then read index 0 and index 3 -> each read_ack exactly 1 cycle after request; data 0 and 0.
- enable=1, arm=1; predicates 0x00->0x05 at cycle 10, then ->0x03 at cycle 20 -> STATUS count=2. TRACE reads return {10,0x05} then {20,0x03}; a third read returns 0 and count stays 0.
- Arm, toggle predicates 17 times without popping (TRACE_DEPTH=16) -> count=16, overflow=1. First entry popped is the first change. On a full FIFO, one pop plus capture in the same cycle leaves count=16.
- freeze_on_halt=1; registers[3]=0xDEADBEEF; assert core_halted, then change registers[3] to 0 -> index 11 reads 0xDEADBEEF, STATUS bits1:0=2'b11, CYCLE constant.
- Write CONTROL=0x5 while frozen -> frozen=0, overflow=0, count=0, CYCLE restarts from 0, arm=1.
- enable=0, write CONTROL=0x1, then read index 2 -> both acknowledged; read data 0. After enable=1, a read of index 2 returns 0 (the write was discarded).

Source files
------------

// File: rtl/core_trace_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : core_trace_monitor_if
// Description : Host MMIO bus between a processing element's host and its
//               debug trace monitor. One read channel and one write channel.
//               Each channel uses a req/ack handshake, and the ack is a
//               one-cycle pulse.
//   read_req    host -> monitor  read request
//   read_index  host -> monitor  read word index
//   read_ack    monitor -> host  read acknowledge (read_data valid)
//   read_data   monitor -> host  read data
//   write_req   host -> monitor  write request
//   write_index host -> monitor  write word index
//   write_data  host -> monitor  write data
//   write_ack   monitor -> host  write acknowledge
// Revision    : 1.0 - initial release
// ============================================================================
interface core_trace_monitor_if #(
    parameter int WORD_WIDTH  = 32,
    parameter int INDEX_WIDTH = 8
);
    logic                   read_req;
    logic [INDEX_WIDTH-1:0] read_index;
    logic                   read_ack;
    logic [WORD_WIDTH-1:0]  read_data;
    logic                   write_req;
    logic [INDEX_WIDTH-1:0] write_index;
    logic [WORD_WIDTH-1:0]  write_data;
    logic                   write_ack;

    modport master (
        output read_req, read_index, write_req, write_index, write_data,
        input  read_ack, read_data, write_ack
    );

    modport slave (
        input  read_req, read_index, write_req, write_index, write_data,
        output read_ack, read_data, write_ack
    );
endinterface
`default_nettype wire

// File: rtl/core_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : core_trace_monitor
// Description : Memory-mapped debug monitor for one processing element core.
//               It snapshots the halted flag, the predicates and the register
//               file into local buffers. It also keeps a free-running cycle
//               counter and records predicate changes in a timestamped trace
//               FIFO. The monitor can freeze itself when the core halts.
//               Host reads and writes are registered and acknowledged one
//               cycle after acceptance.
//   clock            positive-edge clock
//   reset            synchronous, active-high reset
//   enable           block enable; when low, requests are acked but inert
//   host             MMIO host bus (slave side of core_trace_monitor_if)
//   core_halted      core halted flag
//   core_predicates  core predicate state
//   core_registers   core register file (unpacked array)
// Register map (word index):
//   0 STATUS   bit0 halted, bit1 frozen, bit2 overflow, [15:8] FIFO count
//   1 PREDICATES buffered predicates, zero-extended
//   2 CONTROL  bit0 arm, bit1 freeze_on_halt, bit2 clear (write-only)
//   3 CYCLE    cycle counter
//   4 TRACE    oldest trace entry, popped on read (0 when empty)
//   8..        buffered core registers
// Constraints : NUM_PREDICATES < WORD_WIDTH, WORD_WIDTH >= 16,
//               TRACE_DEPTH a power of two >= 2,
//               8 + NUM_REGISTERS <= 2**INDEX_WIDTH
// Revision    : 1.0 - initial release
// ============================================================================
module core_trace_monitor #(
    parameter int WORD_WIDTH     = 32,
    parameter int NUM_PREDICATES = 8,
    parameter int NUM_REGISTERS  = 8,
    parameter int TRACE_DEPTH    = 16,
    parameter int INDEX_WIDTH    = 8
) (
    input  wire                      clock,
    input  wire                      reset,
    input  wire                      enable,
    core_trace_monitor_if.slave      host,
    input  wire                      core_halted,
    input  wire [NUM_PREDICATES-1:0] core_predicates,
    input  wire [WORD_WIDTH-1:0]     core_registers [NUM_REGISTERS]
);

    localparam int c_PTR_W   = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_SEL_W   = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;
    localparam int c_STAMP_W = WORD_WIDTH - NUM_PREDICATES;

    localparam logic [INDEX_WIDTH-1:0] c_IDX_STATUS     = INDEX_WIDTH'(0);
    localparam logic [INDEX_WIDTH-1:0] c_IDX_PREDICATES = INDEX_WIDTH'(1);
    localparam logic [INDEX_WIDTH-1:0] c_IDX_CONTROL    = INDEX_WIDTH'(2);
    localparam logic [INDEX_WIDTH-1:0] c_IDX_CYCLE      = INDEX_WIDTH'(3);
    localparam logic [INDEX_WIDTH-1:0] c_IDX_TRACE      = INDEX_WIDTH'(4);
    localparam logic [INDEX_WIDTH-1:0] c_IDX_REG_BASE   = INDEX_WIDTH'(8);
    localparam logic [INDEX_WIDTH-1:0] c_NUM_REGS_IDX   = INDEX_WIDTH'(NUM_REGISTERS);
    localparam logic [c_CNT_W-1:0]     c_DEPTH          = c_CNT_W'(TRACE_DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                      r_read_ack;
    logic [WORD_WIDTH-1:0]     r_read_data;
    logic                      r_write_ack;

    logic                      r_halted_buf;
    logic [NUM_PREDICATES-1:0] r_pred_buf;
    logic [WORD_WIDTH-1:0]     r_reg_buf [NUM_REGISTERS];
    logic [WORD_WIDTH-1:0]     r_cycle;

    logic                      r_arm;
    logic                      r_freeze_on_halt;
    logic                      r_frozen;
    logic                      r_overflow;

    logic [WORD_WIDTH-1:0]     r_fifo_mem [TRACE_DEPTH];
    logic [c_PTR_W-1:0]        r_wr_ptr;
    logic [c_PTR_W-1:0]        r_rd_ptr;
    logic [c_CNT_W-1:0]        r_count;

    // ------------------------------------------------------------------------
    // Handshake and decode
    // ------------------------------------------------------------------------
    logic                      w_read_accept;
    logic                      w_write_accept;
    logic                      w_ctrl_write;
    logic                      w_clear;
    logic                      w_active;
    logic                      w_fifo_empty;
    logic                      w_fifo_full;
    logic                      w_pop;
    logic                      w_capture;
    logic                      w_push;
    logic                      w_drop;
    logic [WORD_WIDTH-1:0]     w_entry;
    logic [INDEX_WIDTH-1:0]    w_reg_offset;
    logic [c_SEL_W-1:0]        w_reg_sel;
    logic                      w_reg_hit;
    logic [WORD_WIDTH-1:0]     w_status;
    logic [WORD_WIDTH-1:0]     w_read_value;

    // A held request is not re-accepted while its own ack is out, which
    // gives one transfer per two cycles on each channel.
    assign w_read_accept  = host.read_req  && !r_read_ack;
    assign w_write_accept = host.write_req && !r_write_ack;

    // A disabled block acknowledges writes but does not apply them.
    assign w_ctrl_write = w_write_accept && enable && (host.write_index == c_IDX_CONTROL);
    assign w_clear      = w_ctrl_write && host.write_data[2];

    // Sampling, counting and capture all stop while disabled or frozen.
    assign w_active = enable && !r_frozen;

    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == c_DEPTH);

    // The pop happens at acceptance, so its data is ready for the registered
    // response on the following cycle.
    assign w_pop = w_read_accept && enable && (host.read_index == c_IDX_TRACE) && !w_fifo_empty;

    // The predicate buffer holds last cycle's predicates. Any difference is a
    // change worth recording.
    assign w_capture = r_arm && w_active && (core_predicates != r_pred_buf);

    // A pop on the same edge frees a slot, so a capture into a full FIFO
    // still lands. Clear wins over any capture in the same cycle.
    assign w_push = w_capture && !w_clear && (!w_fifo_full || w_pop);
    assign w_drop = w_capture && !w_clear && w_fifo_full && !w_pop;

    // The timestamp is the counter value before this cycle's increment.
    assign w_entry = {r_cycle[c_STAMP_W-1:0], core_predicates};

    assign w_reg_offset = host.read_index - c_IDX_REG_BASE;
    assign w_reg_sel    = w_reg_offset[c_SEL_W-1:0];
    assign w_reg_hit    = (host.read_index >= c_IDX_REG_BASE) && (w_reg_offset < c_NUM_REGS_IDX);

    always_comb begin
        w_status       = '0;
        w_status[0]    = r_halted_buf;
        w_status[1]    = r_frozen;
        w_status[2]    = r_overflow;
        w_status[15:8] = 8'(r_count);

        w_read_value = '0;
        if (enable) begin
            if (w_reg_hit) begin
                w_read_value = r_reg_buf[w_reg_sel];
            end else begin
                case (host.read_index)
                    c_IDX_STATUS:     w_read_value = w_status;
                    c_IDX_PREDICATES: w_read_value = WORD_WIDTH'(r_pred_buf);
                    c_IDX_CONTROL:    w_read_value = WORD_WIDTH'({r_freeze_on_halt, r_arm});
                    c_IDX_CYCLE:      w_read_value = r_cycle;
                    c_IDX_TRACE: begin
                        if (!w_fifo_empty) begin
                            w_read_value = r_fifo_mem[r_rd_ptr];
                        end
                    end
                    default:          w_read_value = '0;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Host responses
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_read_ack  <= 1'b0;
            r_read_data <= '0;
            r_write_ack <= 1'b0;
        end else begin
            r_read_ack  <= w_read_accept;
            r_read_data <= w_read_accept ? w_read_value : '0;
            r_write_ack <= w_write_accept;
        end
    end

    assign host.read_ack  = r_read_ack;
    assign host.read_data = r_read_data;
    assign host.write_ack = r_write_ack;

    // ------------------------------------------------------------------------
    // Control and status
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_arm            <= 1'b0;
            r_freeze_on_halt <= 1'b0;
            r_frozen         <= 1'b0;
            r_overflow       <= 1'b0;
        end else begin
            if (w_ctrl_write) begin
                r_arm            <= host.write_data[0];
                r_freeze_on_halt <= host.write_data[1];
            end

            // The freeze test uses the settings in force this cycle, so a
            // write that arms freeze_on_halt only takes effect afterwards.
            if (w_clear) begin
                r_frozen <= 1'b0;
            end else if (r_freeze_on_halt && enable && core_halted) begin
                r_frozen <= 1'b1;
            end

            if (w_clear) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Snapshot buffers and cycle counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_halted_buf <= 1'b0;
            r_pred_buf   <= '0;
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                r_reg_buf[i] <= '0;
            end
        end else if (w_active) begin
            // On the edge that sets frozen, the buffers still load. The
            // halted flag that caused the freeze is therefore visible.
            r_halted_buf <= core_halted;
            r_pred_buf   <= core_predicates;
            r_reg_buf    <= core_registers;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || w_clear) begin
            r_cycle <= '0;
        end else if (w_active && !core_halted) begin
            r_cycle <= r_cycle + WORD_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Trace FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset || w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // The storage needs no reset. The count decides what is readable, and
    // an empty FIFO reads as 0 through the mux.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= w_entry;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_trace_monitor
// Description : Self-checking bench for core_trace_monitor. The reference
//               model keeps the trace as a queue and the monitor state as
//               plain variables. A compare process checks acks and read data
//               after every clock edge. The directed part pins the model with
//               hand-computed values, and a randomized phase follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_trace_monitor;

    localparam int W  = 32;
    localparam int NP = 8;
    localparam int NR = 8;
    localparam int D  = 16;
    localparam int IW = 8;

    logic          clock           = 1'b0;
    logic          reset           = 1'b1;
    logic          enable          = 1'b0;
    logic          read_req        = 1'b0;
    logic [IW-1:0] read_index      = '0;
    logic          write_req       = 1'b0;
    logic [IW-1:0] write_index     = '0;
    logic [W-1:0]  write_data      = '0;
    logic          core_halted     = 1'b0;
    logic [NP-1:0] core_predicates = '0;
    logic [W-1:0]  core_registers [NR];
    wire           read_ack;
    wire           write_ack;
    wire  [W-1:0]  read_data;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    always #5 clock = ~clock;

    core_trace_monitor_if #(.WORD_WIDTH(W), .INDEX_WIDTH(IW)) host_if ();

    assign host_if.read_req    = read_req;
    assign host_if.read_index  = read_index;
    assign host_if.write_req   = write_req;
    assign host_if.write_index = write_index;
    assign host_if.write_data  = write_data;
    assign read_ack            = host_if.read_ack;
    assign read_data           = host_if.read_data;
    assign write_ack           = host_if.write_ack;

    core_trace_monitor #(
        .WORD_WIDTH     (W),
        .NUM_PREDICATES (NP),
        .NUM_REGISTERS  (NR),
        .TRACE_DEPTH    (D),
        .INDEX_WIDTH    (IW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .host            (host_if.slave),
        .core_halted     (core_halted),
        .core_predicates (core_predicates),
        .core_registers  (core_registers)
    );

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    bit            m_halted, m_frozen, m_overflow, m_arm, m_foh;
    logic [NP-1:0] m_preds;
    logic [W-1:0]  m_regs [NR];
    logic [W-1:0]  m_cycle;
    logic [W-1:0]  m_fifo [$];
    bit            m_rack, m_wack;
    logic [W-1:0]  m_rdata;

    // Advance the model by one clock edge. It uses the inputs that are
    // currently driven.
    task automatic model_step();
        logic [W-1:0] value;
        bit rd_acc, wr_acc, ctrl_wr, clear, capture, was_frozen, was_foh;
        int idx;
        if (reset) begin
            m_halted = 0; m_frozen = 0; m_overflow = 0; m_arm = 0; m_foh = 0;
            m_preds = '0; m_cycle = '0;
            foreach (m_regs[i]) m_regs[i] = '0;
            m_fifo.delete();
            m_rack = 0; m_wack = 0; m_rdata = '0;
            return;
        end
        rd_acc = read_req && !m_rack;
        wr_acc = write_req && !m_wack;
        idx    = int'(read_index);
        value  = '0;
        if (rd_acc && enable) begin
            if (idx >= 8 && idx < 8 + NR)  value = m_regs[idx - 8];
            else if (idx == 0)             value = {16'd0, 8'(m_fifo.size()), 5'd0, m_overflow, m_frozen, m_halted};
            else if (idx == 1)             value = W'(m_preds);
            else if (idx == 2)             value = W'({m_foh, m_arm});
            else if (idx == 3)             value = m_cycle;
            else if (idx == 4 && m_fifo.size() > 0) value = m_fifo.pop_front();
        end
        ctrl_wr    = wr_acc && enable && (write_index == 8'd2);
        clear      = ctrl_wr && write_data[2];
        capture    = m_arm && enable && !m_frozen && (core_predicates != m_preds);
        was_frozen = m_frozen;
        was_foh    = m_foh;
        if (clear) begin
            m_fifo.delete();
            m_overflow = 0;
        end else if (capture) begin
            if (m_fifo.size() < D) m_fifo.push_back({m_cycle[W-NP-1:0], core_predicates});
            else                   m_overflow = 1;
        end
        if (ctrl_wr) begin
            m_arm = write_data[0];
            m_foh = write_data[1];
        end
        if (clear)                                  m_frozen = 0;
        else if (was_foh && enable && core_halted)  m_frozen = 1;
        if (clear)                                        m_cycle = '0;
        else if (enable && !was_frozen && !core_halted)   m_cycle = m_cycle + 1;
        if (enable && !was_frozen) begin
            m_halted = core_halted;
            m_preds  = core_predicates;
            foreach (m_regs[i]) m_regs[i] = core_registers[i];
        end
        m_rack  = rd_acc;
        m_wack  = wr_acc;
        m_rdata = value;
    endtask

    task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Compare process: DUT against model just after every active edge.
    always @(posedge clock) begin
        #1;
        if (check_en) begin
            check("read_ack", {31'd0, read_ack}, {31'd0, m_rack});
            check("write_ack", {31'd0, write_ack}, {31'd0, m_wack});
            if (m_rack) check("read_data", read_data, m_rdata);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic cycle();
        model_step();
        @(posedge clock);
        #2;
    endtask

    task automatic do_read(input logic [IW-1:0] idx, input logic [W-1:0] expected, input string name);
        read_req   = 1'b1;
        read_index = idx;
        cycle();
        read_req = 1'b0;
        check({name, " ack"}, {31'd0, read_ack}, 32'd1);
        check(name, read_data, expected);
        check({name, " model"}, m_rdata, expected);
        cycle();
        check({name, " ack drop"}, {31'd0, read_ack}, 32'd0);
    endtask

    task automatic do_write(input logic [IW-1:0] idx, input logic [W-1:0] data, input string name);
        write_req   = 1'b1;
        write_index = idx;
        write_data  = data;
        cycle();
        write_req = 1'b0;
        check({name, " ack"}, {31'd0, write_ack}, 32'd1);
        cycle();
        check({name, " ack drop"}, {31'd0, write_ack}, 32'd0);
    endtask

    function automatic logic [IW-1:0] pick_index();
        int r;
        r = $urandom_range(0, 9);
        if (r < 5)  return IW'(r);
        if (r == 5) return IW'($urandom_range(5, 7));
        if (r < 9)  return IW'(8 + $urandom_range(0, NR - 1));
        return IW'($urandom);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        for (int i = 0; i < NR; i++) core_registers[i] = 32'h1111_1111 * (i + 1);
        enable = 1'b1;
        reset  = 1'b1;
        cycle();
        check_en = 1'b1;
        cycle();
        cycle();
        check("reset read_ack", {31'd0, read_ack}, 32'd0);
        check("reset write_ack", {31'd0, write_ack}, 32'd0);
        check("reset read_data", read_data, 32'd0);
        reset = 1'b0;

        // Reads right after reset
        do_read(8'd3, 32'd0, "reset cycle");
        do_read(8'd0, 32'd0, "reset status");

        // Two predicate changes at counter values 10 and 20
        do_write(8'd2, 32'h5, "ctrl arm clear");
        repeat (9) cycle();
        core_predicates = 8'h05;
        cycle();
        repeat (9) cycle();
        core_predicates = 8'h03;
        cycle();
        do_read(8'd0, 32'h0000_0200, "status two entries");
        do_read(8'd4, 32'h0000_0A05, "trace first");
        do_read(8'd4, 32'h0000_1403, "trace second");
        do_read(8'd4, 32'h0000_0000, "trace empty");
        do_read(8'd0, 32'h0000_0000, "status drained");

        // Overflow: 17 changes into a 16-deep FIFO
        do_write(8'd2, 32'h5, "ctrl clear again");
        for (int i = 0; i < 17; i++) begin
            core_predicates = 8'h10 + 8'(i);
            cycle();
        end
        do_read(8'd0, 32'h0000_1004, "status full overflow");
        core_predicates = 8'h33;
        do_read(8'd4, 32'h0000_0110, "trace pop while full");
        do_read(8'd0, 32'h0000_1004, "status still full");

        // Freeze on halt
        core_registers[3] = 32'hDEAD_BEEF;
        do_write(8'd2, 32'h3, "ctrl freeze on halt");
        core_halted = 1'b1;
        cycle();
        core_registers[3] = 32'h0;
        core_predicates   = 8'h44;
        repeat (3) cycle();
        do_read(8'd11, 32'hDEAD_BEEF, "frozen register");
        do_read(8'd0, 32'h0000_1007, "status frozen");

        // Clear while frozen
        core_halted     = 1'b0;
        core_predicates = 8'h33;
        do_write(8'd2, 32'h5, "ctrl clear frozen");
        do_read(8'd3, 32'h1, "cycle restart");
        do_read(8'd0, 32'h0, "status cleared");
        do_read(8'd2, 32'h1, "control arm");

        // Disabled block
        do_write(8'd2, 32'h0, "ctrl zero");
        enable = 1'b0;
        do_write(8'd2, 32'h1, "ctrl write disabled");
        do_read(8'd2, 32'h0, "control read disabled");
        enable = 1'b1;
        do_read(8'd2, 32'h0, "control after disabled write");

        // Randomized phase
        for (int n = 0; n < 4000; n++) begin
            reset       = ($urandom_range(0, 999) == 0);
            enable      = ($urandom_range(0, 15) != 0);
            core_halted = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 2) == 0) core_predicates = 8'($urandom);
            core_registers[$urandom_range(0, NR - 1)] = $urandom;
            read_req    = ($urandom_range(0, 1) == 1);
            read_index  = pick_index();
            write_req   = ($urandom_range(0, 5) == 0);
            write_index = ($urandom_range(0, 3) == 0) ? IW'($urandom) : 8'd2;
            write_data  = $urandom;
            write_data[1] = ($urandom_range(0, 3) == 0);
            write_data[2] = ($urandom_range(0, 15) == 0);
            cycle();
        end
        reset     = 1'b0;
        read_req  = 1'b0;
        write_req = 1'b0;
        repeat (3) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
